// File: rtl/mul_fp_mac_pipe_if.sv
// Handshake bundle between operand fetch, the fp MAC pipeline and psum writeback.
interface mul_fp_mac_pipe_if #(
    parameter int MAN_W = 5,
    parameter int EXP_W = 2,
    parameter int ACC_W = 24
);
    localparam int F = MAN_W + 1;

    logic                    in_vld;
    logic                    in_rdy;
    logic                    in_last;
    logic signed [F-1:0]     op_a_dat;
    logic signed [F-1:0]     op_b_dat;
    logic signed [F-1:0]     op_c_dat;
    logic        [EXP_W-1:0] op_a_exp;
    logic        [EXP_W-1:0] op_b_exp;
    logic        [EXP_W-1:0] op_c_exp;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [ACC_W-1:0] out_dat;
    logic                    out_ovf;

    modport master (
        output in_vld, in_last, op_a_dat, op_b_dat, op_c_dat,
        output op_a_exp, op_b_exp, op_c_exp, out_rdy,
        input  in_rdy, out_vld, out_dat, out_ovf
    );

    modport slave (
        input  in_vld, in_last, op_a_dat, op_b_dat, op_c_dat,
        input  op_a_exp, op_b_exp, op_c_exp, out_rdy,
        output in_rdy, out_vld, out_dat, out_ovf
    );
endinterface

// File: rtl/mul_fp_mac_pipe.sv
// Three-stage fp MAC: a*b*2^(ea+eb) + c*2^ec via radix-4 Booth and a CSA chain,
// accumulated over a group of beats with optional saturation and a sticky overflow flag.
module mul_fp_mac_pipe #(
    parameter int MAN_W = 5,
    parameter int EXP_W = 2,
    parameter int ACC_W = 24,
    parameter int SAT   = 0
) (
    input logic              clk,
    input logic              rst_n,
    mul_fp_mac_pipe_if.slave bus
);
    localparam int F     = MAN_W + 1;
    localparam int NDIG  = (F + 1) / 2;
    localparam int BW    = 2 * NDIG;
    localparam int NTERM = NDIG + 2;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic             adv;
    logic             out_vld_q;
    logic             out_ovf_q;
    logic [ACC_W-1:0] out_dat_q;

    // Any stall comes only from an unconsumed result, so the whole pipe freezes together.
    assign adv         = !(out_vld_q && !bus.out_rdy);
    assign bus.in_rdy  = adv;
    assign bus.out_vld = out_vld_q;
    assign bus.out_dat = out_dat_q;
    assign bus.out_ovf = out_ovf_q;

    logic                    v0, last0;
    logic signed [F-1:0]     a0, b0, c0;
    logic        [EXP_W-1:0] ea0, eb0, ec0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so every stage samples pre-edge values.
        if (!rst_n) begin
            v0    <= 1'b0;
            last0 <= 1'b0;
            a0    <= '0;
            b0    <= '0;
            c0    <= '0;
            ea0   <= '0;
            eb0   <= '0;
            ec0   <= '0;
        end else if (adv) begin
            v0    <= bus.in_vld;
            last0 <= bus.in_last;
            a0    <= bus.op_a_dat;
            b0    <= bus.op_b_dat;
            c0    <= bus.op_c_dat;
            ea0   <= bus.op_a_exp;
            eb0   <= bus.op_b_exp;
            ec0   <= bus.op_c_exp;
        end
    end

    logic signed [ACC_W-1:0] a_ext;
    logic        [BW:0]      b_ext;
    logic        [ACC_W-1:0] terms [NTERM];
    logic        [ACC_W-1:0] sum_c, carry_c;

    assign a_ext = ACC_W'(a0);
    assign b_ext = {BW'(b0), 1'b0};

    always_comb begin : booth
        int               sh;
        logic [2:0]       trip;
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] corr;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        terms = '{default: '0};
        sh    = int'(ea0) + int'(eb0);
        trip  = '0;
        mag   = '0;
        corr  = '0;
        for (int i = 0; i < NDIG; i++) begin
            trip = b_ext[2*i +: 3];
            if (trip[1] ^ trip[0])                   mag = a_ext;
            else if (trip == 3'b011 || trip == 3'b100) mag = a_ext << 1;
            else                                     mag = '0;
            // Negative digits use ~x here plus a +1 at the digit's LSB folded into corr.
            if (trip[2]) mag = ~mag;
            terms[i] = mag << (2 * i + sh);
            corr     = corr | (ACC_W'(trip[2]) << (2 * i + sh));
        end
        terms[NDIG]     = corr;
        terms[NDIG + 1] = ACC_W'(c0) << ec0;
    end

    always_comb begin : csa
        logic [ACC_W-1:0] maj;
        sum_c   = terms[0];
        carry_c = terms[1];
        maj     = '0;
        for (int j = 2; j < NTERM; j++) begin
            maj     = (sum_c & carry_c) | (sum_c & terms[j]) | (carry_c & terms[j]);
            sum_c   = sum_c ^ carry_c ^ terms[j];
            carry_c = maj << 1;
        end
    end

    logic             v1, last1;
    logic [ACC_W-1:0] sum1, carry1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            last1  <= 1'b0;
            sum1   <= '0;
            carry1 <= '0;
        end else if (adv) begin
            v1     <= v0;
            last1  <= last0;
            sum1   <= sum_c;
            carry1 <= carry_c;
        end
    end

    logic [ACC_W-1:0] acc, term, acc_raw, acc_next;
    logic             ovf_acc, ovf_next;

    always_comb begin
        term     = sum1 + carry1;
        acc_raw  = acc + term;
        ovf_next = (acc[ACC_W-1] == term[ACC_W-1]) && (acc_raw[ACC_W-1] != acc[ACC_W-1]);
        acc_next = acc_raw;
        if (SAT != 0 && ovf_next) acc_next = term[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            if (out_vld_q && bus.out_rdy) out_vld_q <= 1'b0;
            // A new result may load on the same edge the previous one is consumed.
            if (adv && v1) begin
                if (last1) begin
                    out_dat_q <= acc_next;
                    out_ovf_q <= ovf_acc | ovf_next;
                    out_vld_q <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                end else begin
                    acc     <= acc_next;
                    ovf_acc <= ovf_acc | ovf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_fp_mac_pipe.sv
// Bench for mul_fp_mac_pipe: three instances (24-bit wrap, 18-bit sat, 18-bit wrap) share
// one stimulus stream and are scored against an arithmetic group-sum model.
module tb_mul_fp_mac_pipe;
    localparam int MAN_W = 5;
    localparam int EXP_W = 2;
    localparam int F     = MAN_W + 1;
    localparam int NI    = 3;
    localparam int BOUND = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_vld  = 1'b0;
    logic             in_last = 1'b0;
    logic             out_rdy = 1'b1;
    logic [F-1:0]     a_d = '0, b_d = '0, c_d = '0;
    logic [EXP_W-1:0] ea_d = '0, eb_d = '0, ec_d = '0;

    mul_fp_mac_pipe_if #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(24)) bus0 ();
    mul_fp_mac_pipe_if #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(18)) bus1 ();
    mul_fp_mac_pipe_if #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(18)) bus2 ();

    assign bus0.in_vld = in_vld;  assign bus0.in_last = in_last; assign bus0.out_rdy = out_rdy;
    assign bus0.op_a_dat = a_d;   assign bus0.op_b_dat = b_d;    assign bus0.op_c_dat = c_d;
    assign bus0.op_a_exp = ea_d;  assign bus0.op_b_exp = eb_d;   assign bus0.op_c_exp = ec_d;
    assign bus1.in_vld = in_vld;  assign bus1.in_last = in_last; assign bus1.out_rdy = out_rdy;
    assign bus1.op_a_dat = a_d;   assign bus1.op_b_dat = b_d;    assign bus1.op_c_dat = c_d;
    assign bus1.op_a_exp = ea_d;  assign bus1.op_b_exp = eb_d;   assign bus1.op_c_exp = ec_d;
    assign bus2.in_vld = in_vld;  assign bus2.in_last = in_last; assign bus2.out_rdy = out_rdy;
    assign bus2.op_a_dat = a_d;   assign bus2.op_b_dat = b_d;    assign bus2.op_c_dat = c_d;
    assign bus2.op_a_exp = ea_d;  assign bus2.op_b_exp = eb_d;   assign bus2.op_c_exp = ec_d;

    mul_fp_mac_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(24), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mul_fp_mac_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(18), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mul_fp_mac_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(18), .SAT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int total = 0;
    int bad   = 0;

    typedef struct { longint dat; bit ovf; } res_t;
    int     acc_w [NI] = '{24, 18, 18};
    bit     sat_m [NI] = '{1'b0, 1'b1, 1'b0};
    longint m_acc [NI];
    bit     m_ovf [NI];
    res_t   exp_q [NI][$];

    // Group-sum model: exact integer arithmetic, then range handling per instance.
    task automatic model_beat(input int a, input int b, input int c,
                              input int ea, input int eb, input int ec, input bit last);
        longint term, lim, s;
        bit     ov;
        res_t   r;
        term = longint'(a) * longint'(b) * (longint'(1) << (ea + eb))
             + longint'(c) * (longint'(1) << ec);
        for (int i = 0; i < NI; i++) begin
            lim = longint'(1) << (acc_w[i] - 1);
            s   = m_acc[i] + term;
            ov  = (s > lim - 1) || (s < -lim);
            if (ov) begin
                if (sat_m[i]) s = (s > 0) ? lim - 1 : -lim;
                else          s = (s > 0) ? s - 2 * lim : s + 2 * lim;
            end
            if (last) begin
                r.dat = s;
                r.ovf = m_ovf[i] | ov;
                exp_q[i].push_back(r);
                m_acc[i] = 0;
                m_ovf[i] = 1'b0;
            end else begin
                m_acc[i] = s;
                m_ovf[i] = m_ovf[i] | ov;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
            exp_q[i].delete();
        end
    endtask

    // Handshakes are judged half a cycle before the edge that completes them.
    always @(negedge clk) begin : monitor
        longint od [NI];
        bit     ov [NI];
        bit     vv [NI];
        res_t   e;
        #1;
        if (rst_n) begin
            if (in_vld && bus0.in_rdy)
                model_beat(int'($signed(a_d)), int'($signed(b_d)), int'($signed(c_d)),
                           int'(ea_d), int'(eb_d), int'(ec_d), in_last);
            od[0] = longint'(bus0.out_dat); ov[0] = bus0.out_ovf; vv[0] = bus0.out_vld;
            od[1] = longint'(bus1.out_dat); ov[1] = bus1.out_ovf; vv[1] = bus1.out_vld;
            od[2] = longint'(bus2.out_dat); ov[2] = bus2.out_ovf; vv[2] = bus2.out_vld;
            for (int i = 0; i < NI; i++) begin
                if (vv[i] && out_rdy) begin
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL result_unexpected dut%0d got dat=%0d ovf=%0b", i, od[i], ov[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (od[i] !== e.dat || ov[i] !== e.ovf) begin
                            bad++;
                            $display("FAIL result dut%0d got dat=%0d ovf=%0b want dat=%0d ovf=%0b",
                                     i, od[i], ov[i], e.dat, e.ovf);
                        end
                    end
                end
            end
        end
    end

    function automatic int rnd_man();
        return int'($urandom_range(0, 63)) - 32;
    endfunction

    function automatic int rnd_exp();
        return int'($urandom_range(0, 3));
    endfunction

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic send(input int a, input int b, input int c,
                        input int ea, input int eb, input int ec, input bit last);
        int n = 0;
        @(negedge clk);
        in_vld  = 1'b1;
        in_last = last;
        a_d  = F'(a);      b_d  = F'(b);      c_d  = F'(c);
        ea_d = EXP_W'(ea); eb_d = EXP_W'(eb); ec_d = EXP_W'(ec);
        #1;
        while (!bus0.in_rdy && n < BOUND) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= BOUND) begin
            bad++;
            $display("FAIL send_timeout in_rdy=%0b after %0d cycles, want 1", bus0.in_rdy, n);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0
                || bus0.out_vld) && n < BOUND) begin
            @(negedge clk);
            #2;
            n++;
        end
        total++;
        if (n >= BOUND) begin
            bad++;
            $display("FAIL drain_%s pending=%0d, want 0", tag, exp_q[0].size());
        end
    endtask

    task automatic test_reset();
        model_clear();
        #12;
        total++;
        if (bus0.out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%0b want=0", bus0.out_vld); end
        total++;
        if (bus0.out_dat !== 24'd0) begin bad++; $display("FAIL reset_out_dat got=%0d want=0", bus0.out_dat); end
        total++;
        if (bus1.out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%0b want=0", bus1.out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus0.in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%0b want=1", bus0.in_rdy); end
    endtask

    task automatic test_basic();
        send(16, 8, 3, 1, 0, 2, 1'b1);
        idle();
        @(posedge clk); #1;
        total++;
        if (bus0.out_vld !== 1'b0) begin bad++; $display("FAIL basic_early out_vld got=%0b want=0", bus0.out_vld); end
        @(posedge clk); #1;
        total++;
        if (bus0.out_vld !== 1'b1 || bus0.out_dat !== 24'd268 || bus0.out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency got vld=%0b dat=%0d ovf=%0b want vld=1 dat=268 ovf=0",
                     bus0.out_vld, bus0.out_dat, bus0.out_ovf);
        end
        drain("basic");
    endtask

    task automatic test_most_negative();
        send(-32, -32, -32, 3, 3, 3, 1'b1);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus0.out_vld !== 1'b1 || bus0.out_dat !== 24'd65280) begin
            bad++;
            $display("FAIL most_negative got vld=%0b dat=%0d want vld=1 dat=65280", bus0.out_vld, bus0.out_dat);
        end
        drain("most_negative");
    endtask

    task automatic test_groups();
        for (int k = 0; k < 4; k++) send(1, 1, 0, 0, 0, 0, k == 3);
        send(-1, 1, 0, 0, 0, 0, 1'b1);
        idle();
        @(posedge clk); #1;
        total++;
        if (bus0.out_vld !== 1'b1 || bus0.out_dat !== 24'd4) begin
            bad++;
            $display("FAIL group_four got vld=%0b dat=%0d want vld=1 dat=4", bus0.out_vld, bus0.out_dat);
        end
        @(posedge clk); #1;
        total++;
        if (bus0.out_vld !== 1'b1 || bus0.out_dat !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL group_single got vld=%0b dat=%0h want vld=1 dat=ffffff", bus0.out_vld, bus0.out_dat);
        end
        drain("groups");
    endtask

    task automatic test_back_to_back();
        int n;
        fork
            begin
                for (int g = 0; g < 3; g++) begin
                    send(rnd_man(), rnd_man(), rnd_man(), rnd_exp(), rnd_exp(), rnd_exp(), 1'b0);
                    send(rnd_man(), rnd_man(), rnd_man(), rnd_exp(), rnd_exp(), rnd_exp(), 1'b1);
                end
                idle();
            end
            begin
                @(negedge clk);
                out_rdy = 1'b0;
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!bus0.out_vld && n < BOUND);
                total++;
                if (bus0.out_vld !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_first got vld=%0b after %0d cycles want 1", bus0.out_vld, n);
                end
                for (int k = 0; k < 5; k++) begin
                    total++;
                    if (exp_q[0].size() == 0 || bus0.out_vld !== 1'b1
                        || longint'(bus0.out_dat) !== exp_q[0][0].dat) begin
                        bad++;
                        $display("FAIL stall_hold cycle %0d got vld=%0b dat=%0d want vld=1 dat=%0d",
                                 k, bus0.out_vld, bus0.out_dat, exp_q[0].size() ? exp_q[0][0].dat : 0);
                    end
                    total++;
                    if (bus0.in_rdy !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_in_rdy cycle %0d got=%0b want=0", k, bus0.in_rdy);
                    end
                    @(posedge clk); #1;
                end
                @(negedge clk);
                out_rdy = 1'b1;
            end
        join
        drain("back_to_back");
    endtask

    task automatic test_overflow();
        send(-32, -32, 0, 3, 3, 0, 1'b0);
        send(-32, -32, 0, 3, 3, 0, 1'b1);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus1.out_vld !== 1'b1 || bus1.out_dat !== 18'h1FFFF || bus1.out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sat got vld=%0b dat=%0d ovf=%0b want vld=1 dat=131071 ovf=1",
                     bus1.out_vld, bus1.out_dat, bus1.out_ovf);
        end
        total++;
        if (bus2.out_dat !== 18'h20000 || bus2.out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_wrap got dat=%0d ovf=%0b want dat=-131072 ovf=1", bus2.out_dat, bus2.out_ovf);
        end
        total++;
        if (bus0.out_dat !== 24'd131072 || bus0.out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_wide got dat=%0d ovf=%0b want dat=131072 ovf=0", bus0.out_dat, bus0.out_ovf);
        end
        drain("overflow");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++)
                    send(rnd_man(), rnd_man(), rnd_man(), rnd_exp(), rnd_exp(), rnd_exp(),
                         ($urandom_range(0, 2) == 0) || (k == 59));
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_rdy = ($urandom_range(0, 3) != 0);
                end
                out_rdy = 1'b1;
            end
        join
        drain("random");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_rdy = 1'b0;
        send(9, 7, 5, 2, 1, 3, 1'b1);
        send(-20, 13, 4, 3, 2, 1, 1'b0);
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (bus0.out_vld !== 1'b0 || bus0.out_dat !== 24'd0 || bus0.out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got vld=%0b dat=%0d ovf=%0b want all 0",
                     bus0.out_vld, bus0.out_dat, bus0.out_ovf);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        send(7, -3, 5, 1, 2, 0, 1'b1);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus0.out_vld !== 1'b1 || $signed(bus0.out_dat) !== -24'sd163) begin
            bad++;
            $display("FAIL reset_mid_next got vld=%0b dat=%0d want vld=1 dat=-163",
                     bus0.out_vld, $signed(bus0.out_dat));
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_most_negative();
        test_groups();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
